// File: rtl/shifter_8_if.sv
// Data bundle for the 8-bit shifter: load strobe, direction, parallel data in, register contents out.
interface shifter_8_if;
    logic [7:0] din;
    logic       load;
    logic       LR;
    logic [7:0] dout;

    modport master (
        output din,
        output load,
        output LR,
        input  dout
    );

    modport slave (
        input  din,
        input  load,
        input  LR,
        output dout
    );
endinterface

// File: rtl/shifter_8.sv
// 8-bit registered bidirectional shifter; define SHIFTER8_ROTATE_EN for circular rotate,
// otherwise bits shifted out are lost and zeros fill in from either end.
module shifter_8 (
    input  logic        clk,
    input  logic        reset,
    shifter_8_if.slave  bus
);

    logic [7:0] q;
    logic       fillL;
    logic       fillR;

`ifdef SHIFTER8_ROTATE_EN
    assign fillL = q[7];
    assign fillR = q[0];
`else
    assign fillL = 1'b0;
    assign fillR = 1'b0;
`endif

    // Priority is reset, then load, then a one-position step in the direction LR selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 8'h00;
        end else if (bus.load) begin
            q <= bus.din;
        end else if (bus.LR) begin
            q <= {q[6:0], fillL};
        end else begin
            q <= {fillR, q[7:1]};
        end
    end

    assign bus.dout = q;

endmodule

// File: tb/tb_shifter_8.sv
// Directed plus randomized bench for shifter_8, checked against an arithmetic model of the register.
module tb_shifter_8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   model;

`ifdef SHIFTER8_ROTATE_EN
    localparam bit rotateMode = 1'b1;
`else
    localparam bit rotateMode = 1'b0;
`endif

    shifter_8_if bus ();

    shifter_8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Left step doubles the value; in rotate mode the old MSB comes back as the new LSB.
    function automatic int stepLeft(input int v);
        if (rotateMode) return (v * 2) % 256 + v / 128;
        return (v * 2) % 256;
    endfunction

    function automatic int stepRight(input int v);
        if (rotateMode) return v / 2 + (v % 2) * 128;
        return v / 2;
    endfunction

    task automatic checkOutput(input string tag);
        logic [7:0] expected;
        expected = model[7:0];
        vectors++;
        assert (bus.dout === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: dout=%h expected=%h", tag, bus.dout, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic dir,
                                 input logic [7:0] d, input string tag);
        @(negedge clk);
        reset    = r;
        bus.load = ld;
        bus.LR   = dir;
        bus.din  = d;
        @(posedge clk);
        if (r)        model = 0;
        else if (ld)  model = int'(d);
        else if (dir) model = stepLeft(model);
        else          model = stepRight(model);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic r;
        logic ld;
        vectors     = 0;
        miscompares = 0;
        model       = 0;
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.LR      = 1'b0;
        bus.din     = 8'h00;

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, "reset_with_load0");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, "reset_with_load1");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, i[0], 8'hFF, "zero_after_reset");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h24, "load_24_left");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "left_steps");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h24, "load_24_right");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "right_steps");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h81, "load_81");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "right_81");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, "load_a5");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "toggle_left");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "toggle_right");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "toggle_left2");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, "load_over_left");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "step_after_load");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, "load_over_right");

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, "load_f0");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "f0_step1");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "f0_step2");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A, "reset_mid_shift");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "resume_from_zero");

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i * 37 + 11), "load_every_cycle");

        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            ld = ($urandom_range(0, 3) == 0);
            applyStimulus(r, ld, 1'($urandom), 8'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
